// File: rtl/haraka_perm_core_if.sv
// ---------------------------------------------------------------------------
// haraka_perm_core_if
//   Request/response bundle between a Haraka permutation client and
//   haraka_perm_core.
//   start      : request, honoured only while ready is high
//   mode512    : 1 = Haraka-512, 0 = Haraka-256 (captured with start)
//   din        : 512-bit message, lane k = din[128k+127:128k]
//   ready      : core idle and able to accept a request
//   valid      : one-cycle completion pulse
//   dout       : permutation output XOR input (upper half zero in 256 mode)
//   dout_trunc : Haraka-512 truncated digest (zero in 256 mode)
// ---------------------------------------------------------------------------
interface haraka_perm_core_if;
  logic         start;
  logic         mode512;
  logic [511:0] din;
  logic         ready;
  logic         valid;
  logic [511:0] dout;
  logic [255:0] dout_trunc;

  modport master (
    output start, mode512, din,
    input  ready, valid, dout, dout_trunc
  );

  modport slave (
    input  start, mode512, din,
    output ready, valid, dout, dout_trunc
  );
endinterface

// File: rtl/haraka_perm_core.sv
// ---------------------------------------------------------------------------
// aes_enc_round
//   One combinational AESENC round: ShiftRows, SubBytes, MixColumns, then
//   XOR with the round key. Byte 0 of the AES state sits at bits [7:0];
//   bytes are column-major (byte 4c+r is row r, column c).
//   state_in  : 128-bit input state
//   round_key : 128-bit round key
//   state_out : 128-bit output state
// ---------------------------------------------------------------------------
module aes_enc_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the
  // AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [3:0][7:0] col;
  logic [127:0]    mc;

  always_comb begin
    col = '0;
    mc  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      // ShiftRows folded into the byte fetch: row r of column c comes from
      // column (c + r) mod 4 of the input.
      for (int unsigned r = 0; r < 4; r++)
        col[r] = sbox(state_in[8*(r + 4*((c + r) % 4)) +: 8]);
      mc[32*c      +: 8] = xtime(col[0]) ^ xtime(col[1]) ^ col[1] ^ col[2] ^ col[3];
      mc[32*c + 8  +: 8] = col[0] ^ xtime(col[1]) ^ xtime(col[2]) ^ col[2] ^ col[3];
      mc[32*c + 16 +: 8] = col[0] ^ col[1] ^ xtime(col[2]) ^ xtime(col[3]) ^ col[3];
      mc[32*c + 24 +: 8] = xtime(col[0]) ^ col[0] ^ col[1] ^ col[2] ^ xtime(col[3]);
    end
  end

  assign state_out = mc ^ round_key;

endmodule

// ---------------------------------------------------------------------------
// haraka_perm_core
//   Iterative Haraka v2 permutation (512 or 256 bit), one AES sub-round per
//   clock on four parallel lanes, MIX after every second sub-round and the
//   feed-forward XOR on the final step. Drives the round-constant table
//   (hara_c/round/round_aes) and takes its four outputs as lane keys in the
//   same cycle.
//   CLK, RESET_N   : clock, asynchronous active-low reset
//   bus (slave)    : start/mode512/din request, ready/valid/dout/dout_trunc
//   hara_c         : latched mode to the constant table
//   round          : current Haraka round 0..ROUNDS-1
//   round_aes      : sub-round select, {1'b0,j} (512) or {j,j} (256)
//   rc0_1..rc1_2   : round keys for lanes 0..3
// ---------------------------------------------------------------------------
module haraka_perm_core #(
  parameter int unsigned ROUNDS        = 5,
  parameter int unsigned AES_PER_ROUND = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  haraka_perm_core_if.slave   bus,
  output logic                hara_c,
  output logic [3:0]          round,
  output logic [1:0]          round_aes,
  input  logic [127:0]        rc0_1,
  input  logic [127:0]        rc0_2,
  input  logic [127:0]        rc1_1,
  input  logic [127:0]        rc1_2
);

  localparam logic [3:0] ROUND_LAST = 4'(ROUNDS - 1);
  localparam logic       J_LAST     = 1'(AES_PER_ROUND - 1);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm;
  logic         j_r;
  logic [511:0] st_r;
  logic [511:0] din_r;
  logic [511:0] keys;
  logic [511:0] aes_o;
  logic [511:0] sub_nxt;
  logic [511:0] mix_nxt;
  logic [511:0] ff;
  logic [255:0] trunc;

  function automatic logic [127:0] lo(input logic [127:0] a, input logic [127:0] b);
    return {b[63:32], a[63:32], b[31:0], a[31:0]};
  endfunction

  function automatic logic [127:0] hi(input logic [127:0] a, input logic [127:0] b);
    return {b[127:96], a[127:96], b[95:64], a[95:64]};
  endfunction

  // The reference MIX512 overwrites lanes in place; the intermediate
  // names below keep each step reading the already-updated values.
  function automatic logic [511:0] mix512(input logic [511:0] s);
    logic [127:0] t, n0, n1, n2, n3, m0, m1, m2;
    t  = lo(s[127:0],   s[255:128]);
    n0 = hi(s[127:0],   s[255:128]);
    n1 = lo(s[383:256], s[511:384]);
    n2 = hi(s[383:256], s[511:384]);
    n3 = lo(n0, n2);
    m0 = hi(n0, n2);
    m2 = hi(n1, t);
    m1 = lo(n1, t);
    return {n3, m2, m1, m0};
  endfunction

  function automatic logic [511:0] mix256(input logic [511:0] s);
    return {256'b0, hi(s[127:0], s[255:128]), lo(s[127:0], s[255:128])};
  endfunction

  assign keys = {rc1_2, rc1_1, rc0_2, rc0_1};

  for (genvar k = 0; k < 4; k++) begin : g_lane
    aes_enc_round u_aes (
      .state_in  (st_r[128*k +: 128]),
      .round_key (keys[128*k +: 128]),
      .state_out (aes_o[128*k +: 128])
    );
  end

  always_comb begin
    sub_nxt = hara_c ? aes_o : {256'b0, aes_o[255:0]};
    mix_nxt = hara_c ? mix512(aes_o) : mix256(aes_o);
    ff      = mix_nxt ^ din_r;
    trunc   = hara_c ? {ff[447:384], ff[319:256], ff[255:192], ff[127:64]} : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm            <= IDLE;
      j_r            <= 1'b0;
      st_r           <= '0;
      din_r          <= '0;
      hara_c         <= 1'b0;
      round          <= '0;
      round_aes      <= '0;
      bus.ready      <= 1'b1;
      bus.valid      <= 1'b0;
      bus.dout       <= '0;
      bus.dout_trunc <= '0;
    end else begin
      bus.valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            // Lanes 2-3 stay zero in 256 mode so the shared datapath can
            // always produce a zero upper half.
            st_r      <= bus.mode512 ? bus.din : {256'b0, bus.din[255:0]};
            din_r     <= bus.mode512 ? bus.din : {256'b0, bus.din[255:0]};
            hara_c    <= bus.mode512;
            round     <= '0;
            round_aes <= '0;
            j_r       <= 1'b0;
            bus.ready <= 1'b0;
            fsm       <= RUN;
          end
        end
        RUN: begin
          if (j_r == J_LAST) begin
            st_r      <= mix_nxt;
            j_r       <= 1'b0;
            round_aes <= '0;
            if (round == ROUND_LAST) begin
              bus.dout       <= ff;
              bus.dout_trunc <= trunc;
              bus.valid      <= 1'b1;
              bus.ready      <= 1'b1;
              round          <= '0;
              fsm            <= IDLE;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            st_r      <= sub_nxt;
            j_r       <= 1'b1;
            round_aes <= hara_c ? 2'b01 : 2'b11;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_haraka_perm_core.sv
// ---------------------------------------------------------------------------
// tb_haraka_perm_core
//   Directed bench for haraka_perm_core with a behavioural model of the
//   round_c constant table (Haraka v2 constants) and the published Haraka
//   test vectors as expected results.
// ---------------------------------------------------------------------------
module tb_haraka_perm_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  haraka_perm_core_if bus ();

  logic         hara_c;
  logic [3:0]   round;
  logic [1:0]   round_aes;
  logic [127:0] rc0_1, rc0_2, rc1_1, rc1_2;

  haraka_perm_core #(.ROUNDS(5), .AES_PER_ROUND(2)) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .hara_c    (hara_c),
    .round     (round),
    .round_aes (round_aes),
    .rc0_1     (rc0_1),
    .rc0_2     (rc0_2),
    .rc1_1     (rc1_1),
    .rc1_2     (rc1_2)
  );

  localparam logic [127:0] RC [40] = '{
    128'h0684704c_e620c00a_b2c5fef0_75817b9d, 128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
    128'h3402de2d_53f28498_cf029d60_9f029114, 128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
    128'hcbcfb0cb_4872448b_79eecd1c_be397044, 128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
    128'h67c28f43_5e2e7cd0_e2412761_da4fef1b, 128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
    128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee, 128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
    128'hb2cc0bb9_941723bf_69028b2e_8df69800, 128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
    128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4, 128'h1ea10344_f449a236_32d611ae_bb6a12ee,
    128'haf044988_4b050084_5f9600c9_9ca8eca6, 128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
    128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173, 128'h6260700d_6186b017_37f2efd9_10307d6b,
    128'h5aca45c2_21300443_81c29153_f6fc9ac6, 128'h9223973c_226b68bb_2caf92e8_36d1943a,
    128'hd3bf9238_225886eb_6cbab958_e51071b4, 128'hdb863ce5_aef0c677_933dfddd_24e1128d,
    128'hbb606268_ffeba09c_83e48de3_cb2212b1, 128'h734bd3dc_e2e4d19c_2db91a4e_c72bf77d,
    128'h43bb47c3_61301b43_4b1415c4_2cb3924e, 128'hdba775a8_e707eff6_03b231dd_16eb6899,
    128'h6df3614b_3c755977_8e5e2302_7eca472c, 128'hcda75a17_d6de7d77_6d1be5b9_b88617f9,
    128'hec6b43f0_6ba8e9aa_9d6c069d_a946ee5d, 128'hcb1e6950_f957332b_a2531159_3bf327c1,
    128'h2cee0c75_00da619c_e4ed0353_600ed0d9, 128'hf0b1a5a1_96e90cab_80bbbabc_63a4a350,
    128'hae3db102_5e962988_ab0dde30_938dca39, 128'h17bb8f38_d554a40b_8814f3a8_2e75b442,
    128'h34bb8a5b_5f427fd7_aeb6b779_360a16f6, 128'h26f65241_cbe55438_43ce5918_ffbaafde,
    128'h4ce99a54_b9f3026a_a2ca9cf7_839ec978, 128'hae51a51a_1bdff7be_40c06e28_22901235,
    128'ha0c1613c_ba7ed22b_c173bc0f_48a659cf, 128'h756acc03_02288288_4ad6bdfd_e9c59da1
  };

  function automatic logic [127:0] rc_at(input int unsigned idx);
    return (idx < 40) ? RC[idx] : '0;
  endfunction

  // round_c model: 512 mode uses rc[8r+4j+k], 256 mode rc[4r+2j+k].
  int unsigned rc_base;
  always_comb begin
    if (hara_c) rc_base = 8*int'(round) + 4*int'(round_aes[0]);
    else        rc_base = 4*int'(round) + 2*int'(round_aes[0]);
    rc0_1 = rc_at(rc_base);
    rc0_2 = rc_at(rc_base + 1);
    rc1_1 = rc_at(rc_base + 2);
    rc1_2 = rc_at(rc_base + 3);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Published digests are written byte 0 first; put byte i at [8i+7:8i].
  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[8*(31-i) +: 8];
    return r;
  endfunction

  logic [511:0] v512, v256, alt;
  logic [255:0] exp512_trunc, exp256_lo;

  // One permutation with sequencing checks on every RUN cycle. With poke set,
  // start is pulsed with other data after edges 3 and 7 of the run.
  task automatic run_perm(input string tag, input logic m, input logic [511:0] d,
                          input bit poke, output logic [511:0] o, output logic [255:0] ot);
    int lat;
    int nval;
    logic [3:0] er;
    logic       ej;
    @(posedge clk); #1;
    check({tag, ".ready_idle"}, bus.ready, 1'b1);
    bus.start   = 1'b1;
    bus.mode512 = m;
    bus.din     = d;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.mode512 = ~m;
    bus.din     = ~d;
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (bus.valid || lat >= 10) break;
      er = 4'(lat / 2);
      ej = lat[0];
      check({tag, ".seq"}, {bus.ready, hara_c, er == round, round_aes},
            {1'b0, m, 1'b1, (m ? {1'b0, ej} : {ej, ej})});
      @(posedge clk); #1;
      lat++;
      if (poke) begin
        bus.start = (lat == 3 || lat == 7);
        bus.din   = alt;
      end
    end
    bus.start = 1'b0;
    check({tag, ".latency"}, lat, 10);
    check({tag, ".valid"}, bus.valid, 1'b1);
    check({tag, ".ready_done"}, bus.ready, 1'b1);
    o  = bus.dout;
    ot = bus.dout_trunc;
    nval = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.valid) nval++;
    end
    check({tag, ".no_extra_valid"}, nval, 0);
  endtask

  logic [511:0] o;
  logic [255:0] ot;
  int edge_n, v1, v2, nval;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) v512[8*i +: 8] = 8'(i);
    v256 = '1;
    for (int i = 0; i < 32; i++) v256[8*i +: 8] = 8'(i);
    alt = {16{32'hdeadbeef}};
    exp512_trunc = bswap256(256'hbe7f723b4e80a99813b292287f306f625a6d57331cae5f34dd9277b0945be2aa);
    exp256_lo    = bswap256(256'h8027ccb87949774b78d0545fb72bf70c695c2a0923cbd47bba1159efbf2b2c1c);

    bus.start   = 1'b0;
    bus.mode512 = 1'b0;
    bus.din     = '0;

    #13;
    check("rst.ready", bus.ready, 1'b1);
    check("rst.valid", bus.valid, 1'b0);
    check("rst.dout", bus.dout, '0);
    check("rst.trunc", bus.dout_trunc, '0);
    check("rst.ctl", {hara_c, round, round_aes}, '0);
    #10 rst_n = 1'b1;

    run_perm("h512", 1'b1, v512, 1'b0, o, ot);
    check("h512.trunc", ot, exp512_trunc);

    run_perm("h256", 1'b0, v256, 1'b0, o, ot);
    check("h256.lo", o[255:0], exp256_lo);
    check("h256.hi", o[511:256], '0);
    check("h256.trunc", ot, '0);

    run_perm("busy", 1'b1, v512, 1'b1, o, ot);
    check("busy.trunc", ot, exp512_trunc);

    // Back-to-back: start stays high across the completion cycle.
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.mode512 = 1'b1;
    bus.din     = v512;
    @(posedge clk); #1;
    bus.mode512 = 1'b0;
    bus.din     = v256;
    edge_n = 0;
    v1 = -1;
    v2 = -1;
    while (edge_n < 30) begin
      @(negedge clk);
      if (bus.valid) begin
        if (v1 < 0) begin
          v1 = edge_n;
          ot = bus.dout_trunc;
        end else if (v2 < 0) begin
          v2 = edge_n;
          o = bus.dout;
        end
      end
      @(posedge clk); #1;
      edge_n++;
      if (edge_n == 11) bus.start = 1'b0;
    end
    check("b2b.first_valid", v1, 10);
    check("b2b.spacing", v2 - v1, 11);
    check("b2b.trunc", ot, exp512_trunc);
    check("b2b.dout256", o, {256'b0, exp256_lo});

    // Asynchronous reset in the middle of a run.
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.mode512 = 1'b1;
    bus.din     = v512;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst.ready", bus.ready, 1'b1);
    check("arst.valid", bus.valid, 1'b0);
    check("arst.dout", bus.dout, '0);
    check("arst.trunc", bus.dout_trunc, '0);
    check("arst.ctl", {hara_c, round, round_aes}, '0);
    #3 rst_n = 1'b1;
    nval = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.valid) nval++;
    end
    check("arst.no_valid", nval, 0);
    check("arst.ready_after", bus.ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/haraka_perm_core.md
Name: haraka_perm_core

Overview:
- Iterative Haraka v2 permutation datapath and sequencer for the SPHINCS+ accelerator.
- Sits directly downstream of the round-constant table `round_c`. It drives that table's `hara_c`, `round` and `round_aes` inputs and consumes its four `rc_out*` outputs as AES round keys.
- Executes one AES sub-round per cycle on 4 lanes (Haraka-512) or 2 lanes (Haraka-256), applies MIX, then the feed-forward XOR.
- Four lanes are processed in parallel through instances of the team's combinational `aes_enc_round`. That module is one AESENC (ShiftRows, SubBytes, MixColumns, XOR key), with byte 0 at bits [7:0].

Parameters:
- ROUNDS, 5, Haraka rounds; fixed to match the 40-entry constant table.
- AES_PER_ROUND, 2, AES sub-rounds per Haraka round; fixed.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when ready=1
- mode512  in  1  1=Haraka-512, 0=Haraka-256; latched at start
- din  in  512  message; lane k = din[128k+127:128k]; 256 mode uses lanes 0-1
- ready  out  1  high in IDLE
- valid  out  1  one-cycle done pulse
- dout  out  512  state XOR input (256 mode: [511:256]=0)
- dout_trunc  out  256  512-mode truncation {s3[63:0], s2[63:0], s1[127:64], s0[127:64]}; 0 in 256 mode
- hara_c  out  1  to round_c; equals latched mode
- round  out  4  to round_c; current Haraka round 0..4
- round_aes  out  2  to round_c; 512 mode {1'b0, j}, 256 mode {j, j}
- rc0_1, rc0_2, rc1_1, rc1_2  in  128 each  round_c outputs; keys for lanes 0-3 (256 mode: rc0_1, rc0_2 for lanes 0, 1)

Behaviour:
- Reset (async, RESET_N=0): FSM to IDLE, round=0, j=0, valid=0, dout=0, dout_trunc=0, ready=1, state/din_r=0, hara_c=0. Reset mid-run aborts with no valid pulse.
- States: IDLE, RUN.
- IDLE with start=1 at a clock edge:
  - state <= din, din_r <= din, mode latched.
  - round <= 0, j <= 0, next state RUN, ready <= 0.
- RUN cycle:
  - a_k = aes_enc_round(s_k, key_k) for the active lanes.
  - j=0: s <= a.
  - j=1: s <= MIX(a).
  - Counter: j toggles; round increments when j=1.
- Last step (round=4, j=1):
  - dout <= MIX(a) ^ din_r; dout_trunc updated.
  - valid <= 1 for exactly one cycle; FSM to IDLE, ready <= 1.
- Latency: start sampled at edge 0; 10 RUN edges; valid high after edge 10. Throughput is one permutation per 11 cycles minimum, since a start in the same cycle valid is high is accepted.
- start while RUN is ignored; din and mode512 changes during RUN have no effect.
- round/round_aes/hara_c are registered and stable for the whole cycle; round_c is combinational, so the keys are valid in the same cycle.
- Word notation: w_i = bits [32i+31:32i].
  - lo(a,b) = {b1,a1,b0,a0}, listed high to low.
  - hi(a,b) = {b3,a3,b2,a2}.
- MIX256: s0'=lo(s0,s1), s1'=hi(s0,s1).
- MIX512, sequential in this order:
  - t=lo(s0,s1); s0=hi(s0,s1); s1=lo(s2,s3); s2=hi(s2,s3)
  - s3=lo(s0,s2); s0=hi(s0,s2); s2=hi(s1,t); s1=lo(s1,t)
- 256 mode: lanes 2-3 are held at 0 and excluded from the output.
- dout/dout_trunc hold their value until the next completion or reset.

Test Plan:
- Reset: assert RESET_N=0 mid-RUN (cycle 5) -> ready=1, valid=0, dout=0 asynchronously; no later valid pulse.
- Haraka-512 vector: mode512=1, din bytes 0x00..0x3f (byte i at bits [8i+7:8i]) -> valid 10 cycles after start. dout_trunc bytes, byte 0 first, = be7f723b4e80a99813b292287f306f625a6d57331cae5f34dd9277b0945be2aa.
- Haraka-256 vector: mode512=0, din[255:0] bytes 0x00..0x1f -> dout[255:0] bytes = 8027ccb87949774b78d0545fb72bf70c695c2a0923cbd47bba1159efbf2b2c1c; dout[511:256]=0, dout_trunc=0.
- Sequencing: monitor round/round_aes during 512 run -> (0,0),(0,1),(1,0)...(4,1) with round_aes[1]=0; in 256 run round_aes ∈ {00,11}; hara_c constant during run.
- Busy rejection: pulse start with different din at cycles 3 and 7 of a run -> result unchanged from first vector, exactly one valid.
- Back-to-back: start held high continuously -> second run starts the cycle valid is high; valids 11 cycles apart, both vectors correct.
